ee354_gcd_operand_loader: RTL and testbench
===========================================

// Module: ee354_gcd_operand_loader
// PURPOSE
// Upstream operand-entry and run controller for the ee354_GCD core. Captures A then B from the
// 8 switches on debounced load pulses, rejects zero operands, and issues one-clock Start/Ack
// strobes to the core from a debounced go pulse. Holds Ain/Bin stable while the core runs and
// counts run cycles for display on the SSDs.
// PARAMETERS
// WIDTH       8   operand width (Sw, Ain, Bin)
// ALLOW_ZERO  0   1: accept zero operands; 0: reject them and raise Err
// CNT_W       16  width of the Cyc_Count run-cycle counter
// PORTS
// Clk        in   1      system clock; all logic on posedge
// Reset      in   1      synchronous, active-high reset
// Load_Pulse in   1      one-clock pulse (debounced BtnR SCEN): capture Sw
// Go_Pulse   in   1      one-clock pulse (debounced BtnL SCEN): start or acknowledge
// Sw         in   WIDTH  switch value
// Core_Done  in   1      core q_Done
// Ain        out  WIDTH  operand A to the core
// Bin        out  WIDTH  operand B to the core
// Start      out  1      one-clock start strobe to the core
// Ack        out  1      one-clock acknowledge strobe to the core
// q_EntA, q_EntB, q_Rdy, q_Run, q_Fin  out 1 each  one-hot state outputs for the LEDs
// Err        out  1      last load attempt was a rejected zero
// Cyc_Count  out  CNT_W  clock cycles spent in RUN, saturating
// BEHAVIOUR
// One clock (Clk). Reset is synchronous and active-high. Every register updates only on a
// posedge Clk on which Reset=1 or on which a transition below fires.
// Reset (also mid-operation): state=ENT_A, Ain=Bin=0, Start=Ack=0, Err=0, Cyc_Count=0.
// No Start or Ack is emitted on the reset cycle or the cycle after it.
// All outputs are registered. Start and Ack are high for exactly the one cycle after the
// triggering Go_Pulse sample.
// Zero rule: "valid" means Sw!=0, or ALLOW_ZERO=1.
// State transitions, evaluated each posedge:
// - ENT_A, Load_Pulse: if valid, Ain<=Sw, Err<=0, go to ENT_B. Otherwise Err<=1 and stay.
//   Go_Pulse is ignored.
// - ENT_B, Load_Pulse: if valid, Bin<=Sw, Err<=0, go to RDY. Otherwise Err<=1 and stay.
//   Go_Pulse is ignored.
// - RDY, Go_Pulse: Start<=1, Cyc_Count<=0, go to RUN.
// - RDY, Load_Pulse without Go_Pulse: re-entry. If valid, Ain<=Sw, Err<=0, go to ENT_B.
//   Otherwise Err<=1 and stay in RDY.
// - RDY, Load_Pulse and Go_Pulse in the same cycle: Go wins. Load is dropped; Ain, Bin and Err
//   are unchanged.
// - RUN: Load_Pulse and Go_Pulse are ignored. Ain and Bin are frozen.
//   Core_Done=1: go to FIN.
//   Core_Done=0: Cyc_Count+=1, saturating at all ones.
// - FIN, Go_Pulse: Ack<=1, go to ENT_A. Ain and Bin are kept, not cleared. Load_Pulse is
//   ignored.
// Exactly one of q_EntA..q_Fin is high at all times. Cyc_Count holds its value outside RUN.
// Cycle counting: the first RUN cycle is cycle 1. If Core_Done is first sampled high on
// RUN cycle N, then Cyc_Count=N-1.
// Width rules: Ain and Bin are plain copies of Sw; there is no arithmetic on operands.
// Cyc_Count is unsigned and never wraps.
// TESTING
// 1. Reset for 2 cycles -> q_EntA=1, Ain=Bin=0x00, Err=0, Start=Ack=0, Cyc_Count=0.
// 2. Sw=0x24, Load; Sw=0x36, Load -> Ain=0x24, Bin=0x36, q_Rdy=1, Err=0.
// 3. In ENT_A, Sw=0x00, Load -> Err=1, q_EntA=1, Ain=0. Then Sw=0x05, Load -> Err=0,
//    Ain=0x05, q_EntB=1. Repeat with ALLOW_ZERO=1: Sw=0 is accepted, Err stays 0.
// 4. In RDY, Go -> Start high exactly 1 cycle, q_Run=1. Core_Done rises on RUN cycle 11 ->
//    q_Fin=1, Cyc_Count=10. Go -> Ack high 1 cycle, q_EntA=1, Ain/Bin retained.
// 5. In RDY with Ain=0x24, Sw=0x99, Load and Go in the same cycle -> Start=1, q_Run=1,
//    Ain=0x24. Load and Go during RUN -> no state change, Ain/Bin unchanged.
// 6. Reset asserted on the 3rd RUN cycle -> next cycle q_EntA=1, Ain=Bin=0, Cyc_Count=0,
//    no Ack emitted.

Source files
------------

// File: rtl/ee354_gcd_operand_loader.sv
// ee354_gcd_operand_loader
// Operand-entry and run controller sitting in front of the ee354_GCD core.
// Operands A and B are captured from the switches on debounced load pulses.
// A debounced go pulse issues a one-clock Start, and later a one-clock Ack.
// Ain and Bin stay frozen while the core runs.
// Cycles spent in RUN are counted, saturating, for display on the SSDs.

module ee354_gcd_operand_loader #(
  parameter int WIDTH      = 8,
  parameter int ALLOW_ZERO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load_Pulse,
  input  logic             Go_Pulse,
  input  logic [WIDTH-1:0] Sw,
  input  logic             Core_Done,
  output logic [WIDTH-1:0] Ain,
  output logic [WIDTH-1:0] Bin,
  output logic             Start,
  output logic             Ack,
  output logic             q_EntA,
  output logic             q_EntB,
  output logic             q_Rdy,
  output logic             q_Run,
  output logic             q_Fin,
  output logic             Err,
  output logic [CNT_W-1:0] Cyc_Count
);

  // One-hot encoding, so the LED outputs are simply the state register bits.
  typedef enum logic [4:0] {
    ENT_A = 5'b00001,
    ENT_B = 5'b00010,
    RDY   = 5'b00100,
    RUN   = 5'b01000,
    FIN   = 5'b10000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ain_nxt, bin_nxt;
  logic             err_nxt, start_nxt, ack_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sw_valid;

  // A switch value is an acceptable operand unless it is zero and zeros are disallowed.
  assign sw_valid = (ALLOW_ZERO != 0) || (Sw != '0);

  // State register and all registered outputs; Reset is synchronous and active-high.
  // NOTE: sequential state uses non-blocking (<=) so every register samples the pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ENT_A;
      Ain       <= '0;
      Bin       <= '0;
      Err       <= 1'b0;
      Start     <= 1'b0;
      Ack       <= 1'b0;
      Cyc_Count <= '0;
    end else begin
      state     <= state_nxt;
      Ain       <= ain_nxt;
      Bin       <= bin_nxt;
      Err       <= err_nxt;
      Start     <= start_nxt;
      Ack       <= ack_nxt;
      Cyc_Count <= cnt_nxt;
    end
  end

  // Next-state and next-register-value logic.
  // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ain_nxt   = Ain;
    bin_nxt   = Bin;
    err_nxt   = Err;
    start_nxt = 1'b0;
    ack_nxt   = 1'b0;
    cnt_nxt   = Cyc_Count;

    case (state)
      ENT_A: begin
        // Go is ignored until both operands have been entered.
        if (Load_Pulse) begin
          if (sw_valid) begin
            ain_nxt   = Sw;
            err_nxt   = 1'b0;
            state_nxt = ENT_B;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      ENT_B: begin
        if (Load_Pulse) begin
          if (sw_valid) begin
            bin_nxt   = Sw;
            err_nxt   = 1'b0;
            state_nxt = RDY;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      RDY: begin
        // Go has priority: a simultaneous load is dropped without touching Ain, Bin or Err.
        if (Go_Pulse) begin
          start_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else if (Load_Pulse) begin
          // Re-entry: a new A restarts operand entry.
          if (sw_valid) begin
            ain_nxt   = Sw;
            err_nxt   = 1'b0;
            state_nxt = ENT_B;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      RUN: begin
        // Operands are frozen; the cycle on which Done is seen is not counted.
        if (Core_Done) begin
          state_nxt = FIN;
        end else if (Cyc_Count != CNT_MAX) begin
          cnt_nxt = Cyc_Count + CNT_ONE;
        end
      end

      FIN: begin
        // Ain and Bin are kept so the user can still see what was computed.
        if (Go_Pulse) begin
          ack_nxt   = 1'b1;
          state_nxt = ENT_A;
        end
      end

      default: begin
        state_nxt = ENT_A;
      end
    endcase
  end

  // LED outputs decoded straight from the one-hot state register.
  always_comb begin
    q_EntA = state[0];
    q_EntB = state[1];
    q_Rdy  = state[2];
    q_Run  = state[3];
    q_Fin  = state[4];
  end

endmodule

// File: tb/tb_ee354_gcd_operand_loader.sv
// tb_ee354_gcd_operand_loader
// Directed bench for the operand loader. u0 uses the default configuration (zeros rejected).
// u1 accepts zeros and has a 4-bit counter, so counter saturation can be reached quickly.
// Each step drives one cycle of inputs and pushes the expected post-edge outputs.
// After the edge it pops that entry and compares it against the selected DUT.

module tb_ee354_gcd_operand_loader;

  localparam logic [4:0] S_A = 5'b00001;
  localparam logic [4:0] S_B = 5'b00010;
  localparam logic [4:0] S_R = 5'b00100;
  localparam logic [4:0] S_U = 5'b01000;
  localparam logic [4:0] S_F = 5'b10000;

  typedef struct {
    int         sel;
    string      tag;
    logic [4:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic       e;
    logic       s;
    logic       k;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic        Clk;
  logic        Reset;
  logic        ld0, go0, dn0, ld1, go1, dn1;
  logic [7:0]  sw0, sw1;
  logic [7:0]  ain0, bin0, ain1, bin1;
  logic        start0, ack0, ea0, eb0, rdy0, run0, fin0, err0;
  logic        start1, ack1, ea1, eb1, rdy1, run1, fin1, err1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  ee354_gcd_operand_loader #(.WIDTH(8), .ALLOW_ZERO(0), .CNT_W(16)) u0 (
    .Clk(Clk), .Reset(Reset), .Load_Pulse(ld0), .Go_Pulse(go0), .Sw(sw0),
    .Core_Done(dn0), .Ain(ain0), .Bin(bin0), .Start(start0), .Ack(ack0),
    .q_EntA(ea0), .q_EntB(eb0), .q_Rdy(rdy0), .q_Run(run0), .q_Fin(fin0),
    .Err(err0), .Cyc_Count(cnt0)
  );

  ee354_gcd_operand_loader #(.WIDTH(8), .ALLOW_ZERO(1), .CNT_W(4)) u1 (
    .Clk(Clk), .Reset(Reset), .Load_Pulse(ld1), .Go_Pulse(go1), .Sw(sw1),
    .Core_Done(dn1), .Ain(ain1), .Bin(bin1), .Start(start1), .Ack(ack1),
    .q_EntA(ea1), .q_EntB(eb1), .q_Rdy(rdy1), .q_Run(run1), .q_Fin(fin1),
    .Err(err1), .Cyc_Count(cnt1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus to DUT `sel`, push the expectation, then compare after the edge.
  task automatic step(input int sel, input logic rst, input logic ld, input logic go,
                      input logic done, input logic [7:0] sw, input string tag,
                      input logic [4:0] st, input logic [7:0] a, input logic [7:0] b,
                      input logic e, input logic s, input logic k, input logic [15:0] c);
    exp_t x;
    exp_t y;
    Reset = rst;
    ld0 = (sel == 0) ? ld : 1'b0;  go0 = (sel == 0) ? go : 1'b0;
    dn0 = (sel == 0) ? done : 1'b0; sw0 = (sel == 0) ? sw : 8'h00;
    ld1 = (sel == 1) ? ld : 1'b0;  go1 = (sel == 1) ? go : 1'b0;
    dn1 = (sel == 1) ? done : 1'b0; sw1 = (sel == 1) ? sw : 8'h00;
    x.sel = sel; x.tag = tag; x.st = st; x.a = a; x.b = b;
    x.e = e; x.s = s; x.k = k; x.c = c;
    sb.push_back(x);
    @(posedge Clk);
    #1;
    y = sb.pop_front();
    if (y.sel == 0) begin
      check({y.tag, ".state"}, {27'd0, fin0, run0, rdy0, eb0, ea0}, {27'd0, y.st});
      check({y.tag, ".ain"},   {24'd0, ain0}, {24'd0, y.a});
      check({y.tag, ".bin"},   {24'd0, bin0}, {24'd0, y.b});
      check({y.tag, ".err"},   {31'd0, err0}, {31'd0, y.e});
      check({y.tag, ".start"}, {31'd0, start0}, {31'd0, y.s});
      check({y.tag, ".ack"},   {31'd0, ack0}, {31'd0, y.k});
      check({y.tag, ".cnt"},   {16'd0, cnt0}, {16'd0, y.c});
    end else begin
      check({y.tag, ".state"}, {27'd0, fin1, run1, rdy1, eb1, ea1}, {27'd0, y.st});
      check({y.tag, ".ain"},   {24'd0, ain1}, {24'd0, y.a});
      check({y.tag, ".bin"},   {24'd0, bin1}, {24'd0, y.b});
      check({y.tag, ".err"},   {31'd0, err1}, {31'd0, y.e});
      check({y.tag, ".start"}, {31'd0, start1}, {31'd0, y.s});
      check({y.tag, ".ack"},   {31'd0, ack1}, {31'd0, y.k});
      check({y.tag, ".cnt"},   {28'd0, cnt1}, {16'd0, y.c});
    end
  endtask

  initial begin
    Reset = 1'b1;
    ld0 = 1'b0; go0 = 1'b0; dn0 = 1'b0; sw0 = 8'h00;
    ld1 = 1'b0; go1 = 1'b0; dn1 = 1'b0; sw1 = 8'h00;

    // Reset for two cycles.
    step(0, 1, 0, 0, 0, 8'h00, "rst1", S_A, 8'h00, 8'h00, 0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0, 8'h00, "rst2", S_A, 8'h00, 8'h00, 0, 0, 0, 16'd0);

    // Operand entry with zero rejection; Go is ignored while entering operands.
    step(0, 0, 0, 1, 0, 8'h00, "go_in_enta", S_A, 8'h00, 8'h00, 0, 0, 0, 16'd0);
    step(0, 0, 1, 0, 0, 8'h00, "zero_a",     S_A, 8'h00, 8'h00, 1, 0, 0, 16'd0);
    step(0, 0, 1, 0, 0, 8'h05, "load_a05",   S_B, 8'h05, 8'h00, 0, 0, 0, 16'd0);
    step(0, 0, 1, 0, 0, 8'h00, "zero_b",     S_B, 8'h05, 8'h00, 1, 0, 0, 16'd0);
    step(0, 0, 1, 0, 0, 8'h36, "load_b36",   S_R, 8'h05, 8'h36, 0, 0, 0, 16'd0);

    // Re-entry from RDY: first a rejected zero, then a new A.
    step(0, 0, 1, 0, 0, 8'h00, "rdy_zero",   S_R, 8'h05, 8'h36, 1, 0, 0, 16'd0);
    step(0, 0, 1, 0, 0, 8'h24, "rdy_reload", S_B, 8'h24, 8'h36, 0, 0, 0, 16'd0);
    step(0, 0, 0, 1, 0, 8'h00, "go_in_entb", S_B, 8'h24, 8'h36, 0, 0, 0, 16'd0);
    step(0, 0, 1, 0, 0, 8'h36, "load_b36b",  S_R, 8'h24, 8'h36, 0, 0, 0, 16'd0);

    // Run: Done first seen on RUN cycle 11, so the count reads 10.
    step(0, 0, 0, 1, 0, 8'h00, "go",         S_U, 8'h24, 8'h36, 0, 1, 0, 16'd0);
    for (int i = 1; i <= 10; i++)
      step(0, 0, 0, 0, 0, 8'h00, $sformatf("run%0d", i), S_U, 8'h24, 8'h36, 0, 0, 0, 16'(i));
    step(0, 0, 0, 0, 1, 8'h00, "done",       S_F, 8'h24, 8'h36, 0, 0, 0, 16'd10);
    step(0, 0, 1, 0, 0, 8'h77, "fin_load",   S_F, 8'h24, 8'h36, 0, 0, 0, 16'd10);
    step(0, 0, 0, 1, 0, 8'h00, "ack",        S_A, 8'h24, 8'h36, 0, 0, 1, 16'd10);
    step(0, 0, 0, 0, 0, 8'h00, "post_ack",   S_A, 8'h24, 8'h36, 0, 0, 0, 16'd10);

    // Load and Go together in RDY: Go wins; loads and goes during RUN are ignored.
    step(0, 0, 1, 0, 0, 8'h24, "reload_a",   S_B, 8'h24, 8'h36, 0, 0, 0, 16'd10);
    step(0, 0, 1, 0, 0, 8'h36, "reload_b",   S_R, 8'h24, 8'h36, 0, 0, 0, 16'd10);
    step(0, 0, 1, 1, 0, 8'h99, "ld_go",      S_U, 8'h24, 8'h36, 0, 1, 0, 16'd0);
    step(0, 0, 1, 1, 0, 8'h11, "run_ld_go",  S_U, 8'h24, 8'h36, 0, 0, 0, 16'd1);
    step(0, 0, 0, 0, 0, 8'h00, "run_idle",   S_U, 8'h24, 8'h36, 0, 0, 0, 16'd2);

    // Reset on RUN cycle 3, with Go and Done also high: reset must win, with no Ack.
    step(0, 1, 0, 1, 1, 8'h00, "rst_run",    S_A, 8'h00, 8'h00, 0, 0, 0, 16'd0);
    step(0, 0, 0, 1, 0, 8'h00, "post_rst",   S_A, 8'h00, 8'h00, 0, 0, 0, 16'd0);

    // ALLOW_ZERO=1 instance: zero operands are accepted; the 4-bit counter saturates at 15.
    step(1, 0, 1, 0, 0, 8'h00, "z_load_a",   S_B, 8'h00, 8'h00, 0, 0, 0, 16'd0);
    step(1, 0, 1, 0, 0, 8'h00, "z_load_b",   S_R, 8'h00, 8'h00, 0, 0, 0, 16'd0);
    step(1, 0, 0, 1, 0, 8'h00, "z_go",       S_U, 8'h00, 8'h00, 0, 1, 0, 16'd0);
    for (int i = 1; i <= 20; i++)
      step(1, 0, 0, 0, 0, 8'h00, $sformatf("z_run%0d", i), S_U, 8'h00, 8'h00, 0, 0, 0,
           (i > 15) ? 16'd15 : 16'(i));
    step(1, 0, 0, 0, 1, 8'h00, "z_done",     S_F, 8'h00, 8'h00, 0, 0, 0, 16'd15);
    step(1, 0, 0, 1, 0, 8'h00, "z_ack",      S_A, 8'h00, 8'h00, 0, 0, 1, 16'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
